// File: rtl/action_select_step.sv
// action_select_step: reads the four Q-values of a state, picks an action, and computes next state and reward.
// Optional feature macro EPSILON_GREEDY_EN: LFSR-driven epsilon-greedy exploration (pure greedy when undefined).
module action_select_step #(
    parameter int GRID_WIDTH = 3,
    parameter int Q_WIDTH = 16,
    parameter int GOAL_STATE = 63,
    parameter int REWARD_GOAL = 100,
    parameter int REWARD_WALL = -10,
    parameter int REWARD_STEP = -1,
    parameter int EPSILON = 26,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    localparam int STATE_WIDTH = 2 * GRID_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [STATE_WIDTH-1:0]   i_state,
    output logic [STATE_WIDTH+1:0]   o_q_addr,
    output logic                     o_q_rd,
    input  logic [Q_WIDTH-1:0]       i_q_data,
    output logic [1:0]               o_action,
    output logic [STATE_WIDTH-1:0]   o_next_state,
    output logic [Q_WIDTH-1:0]       o_reward,
    output logic                     o_goal,
    output logic                     o_busy,
    output logic                     o_valid
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DECIDE} fsm_e;
    localparam logic [GRID_WIDTH-1:0] EDGE_MAX = '1;

    fsm_e                   fsm_q, fsm_d;
    logic [1:0]             k_q, k_d;
    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [Q_WIDTH-1:0]     best_q, best_d;
    logic [1:0]             best_idx_q, best_idx_d;
    logic [STATE_WIDTH+1:0] q_addr_q, q_addr_d;
    logic                   q_rd_q, q_rd_d;
    logic [1:0]             action_q, action_d;
    logic [STATE_WIDTH-1:0] next_state_q, next_state_d;
    logic [Q_WIDTH-1:0]     reward_q, reward_d;
    logic                   goal_q, goal_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   explore;
    logic [1:0]             rand_act;
    logic [1:0]             act, data_idx;
    logic                   sample, wall;
    logic [GRID_WIDTH-1:0]  row, col, nrow, ncol;
    logic [STATE_WIDTH-1:0] nxt;

`ifdef EPSILON_GREEDY_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    assign explore  = {1'b0, lfsr_q} < 9'(EPSILON);
    assign rand_act = lfsr_q[1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    // exploration compiled out; the config terms fold to zero and only keep the parameters referenced
    assign explore  = 1'b0 & (EPSILON != 0) & (LFSR_SEED != 8'd0);
    assign rand_act = 2'd0;
`endif

    always_comb begin
        row  = state_q[STATE_WIDTH-1:GRID_WIDTH];
        col  = state_q[GRID_WIDTH-1:0];
        act  = explore ? rand_act : best_idx_q;
        wall = act == 2'd0 ? row == '0 : act == 2'd1 ? row == EDGE_MAX : act == 2'd2 ? col == '0 : col == EDGE_MAX;
        nrow = act == 2'd0 ? row - 1'b1 : act == 2'd1 ? row + 1'b1 : row;
        ncol = act == 2'd2 ? col - 1'b1 : act == 2'd3 ? col + 1'b1 : col;
        nxt  = wall ? state_q : {nrow, ncol};
        // read data lags the address by one cycle, so DRAIN carries action 3
        sample   = (fsm_q == READ && k_q != 2'd0) || fsm_q == DRAIN;
        data_idx = fsm_q == DRAIN ? 2'd3 : k_q - 2'd1;
        fsm_d        = fsm_q;
        k_d          = k_q;
        state_d      = state_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        q_addr_d     = q_addr_q;
        q_rd_d       = 1'b0;
        action_d     = action_q;
        next_state_d = next_state_q;
        reward_d     = reward_q;
        goal_d       = goal_q;
        busy_d       = busy_q && !valid_q;
        valid_d      = 1'b0;
        if (sample && (data_idx == 2'd0 || $signed(i_q_data) > $signed(best_q))) begin
            best_d     = i_q_data;
            best_idx_d = data_idx;
        end
        case (fsm_q)
            IDLE: if (i_valid) begin
                fsm_d      = READ;
                k_d        = 2'd0;
                state_d    = i_state;
                q_addr_d   = {i_state, 2'd0};
                q_rd_d     = 1'b1;
                best_d     = '0;
                best_idx_d = 2'd0;
                busy_d     = 1'b1;
            end
            READ: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) fsm_d = DRAIN;
                else begin
                    q_rd_d   = 1'b1;
                    q_addr_d = {state_q, k_q + 2'd1};
                end
            end
            DRAIN: fsm_d = DECIDE;
            DECIDE: begin
                fsm_d        = IDLE;
                action_d     = act;
                next_state_d = nxt;
                reward_d     = wall ? Q_WIDTH'(REWARD_WALL) : nxt == STATE_WIDTH'(GOAL_STATE) ? Q_WIDTH'(REWARD_GOAL) : Q_WIDTH'(REWARD_STEP);
                goal_d       = nxt == STATE_WIDTH'(GOAL_STATE);
                valid_d      = 1'b1;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            k_q          <= '0;
            state_q      <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            q_addr_q     <= '0;
            q_rd_q       <= 1'b0;
            action_q     <= '0;
            next_state_q <= '0;
            reward_q     <= '0;
            goal_q       <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            k_q          <= k_d;
            state_q      <= state_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            q_addr_q     <= q_addr_d;
            q_rd_q       <= q_rd_d;
            action_q     <= action_d;
            next_state_q <= next_state_d;
            reward_q     <= reward_d;
            goal_q       <= goal_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
        end
    end

    assign o_q_addr     = q_addr_q;
    assign o_q_rd       = q_rd_q;
    assign o_action     = action_q;
    assign o_next_state = next_state_q;
    assign o_reward     = reward_q;
    assign o_goal       = goal_q;
    assign o_busy       = busy_q;
    assign o_valid      = valid_q;
endmodule

// File: tb/tb_action_select_step.sv
// tb_action_select_step: randomized and directed checks of action_select_step against a grid-level reference model.
module tb_action_select_step;
`ifdef EPSILON_GREEDY_EN
    localparam int EPS_ON = 1;
    localparam int EPS = 256;
`else
    localparam int EPS_ON = 0;
    localparam int EPS = 26;
`endif
    localparam int SEED = 'hA5;

    logic        clk = 0, rst_n = 0, i_valid = 0;
    logic [5:0]  i_state = 0;
    logic [7:0]  o_q_addr;
    logic        o_q_rd;
    logic [15:0] i_q_data = 0;
    logic [1:0]  o_action;
    logic [5:0]  o_next_state;
    logic [15:0] o_reward;
    logic        o_goal, o_busy, o_valid;
    int          n_cmp = 0, n_err = 0;
    logic [15:0] q_mem [256];
    int          lfsr_m = SEED;

    action_select_step #(.EPSILON(EPS)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_state(i_state),
        .o_q_addr(o_q_addr), .o_q_rd(o_q_rd), .i_q_data(i_q_data),
        .o_action(o_action), .o_next_state(o_next_state), .o_reward(o_reward),
        .o_goal(o_goal), .o_busy(o_busy), .o_valid(o_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) i_q_data <= q_mem[o_q_addr];
    always @(posedge clk or negedge rst_n) lfsr_m <= !rst_n ? SEED : ((lfsr_m >> 1) ^ ((lfsr_m & 1) != 0 ? 'hB8 : 0));

    function automatic int greedy(input int q[4]);
        int b = 0;
        for (int i = 1; i < 4; i++) if (q[i] > q[b]) b = i;
        return b;
    endfunction

    function automatic void ref_step(input int st, input int q[4], input int l, output int act, output int ns, output int rw);
        int r, c, nr, nc;
        act = (EPS_ON != 0 && l >= 0 && l < EPS) ? l % 4 : greedy(q);
        r = st / 8;
        c = st % 8;
        nr = r + (act == 1 ? 1 : 0) - (act == 0 ? 1 : 0);
        nc = c + (act == 3 ? 1 : 0) - (act == 2 ? 1 : 0);
        if (nr < 0 || nr > 7 || nc < 0 || nc > 7) begin
            ns = st;
            rw = -10;
        end else begin
            ns = nr * 8 + nc;
            rw = ns == 63 ? 100 : -1;
        end
    endfunction

    task automatic do_step(input int st, input int q[4], output int lat, output int busy_n, output int rd_n, output int addr[4], output int l);
        for (int i = 0; i < 4; i++) q_mem[st * 4 + i] = 16'(q[i]);
        @(negedge clk);
        i_valid = 1;
        i_state = 6'(st);
        @(posedge clk);
        #1 i_valid = 0;
        lat = 1; busy_n = 0; rd_n = 0; l = -1;
        for (int i = 0; i < 4; i++) addr[i] = -1;
        while (!o_valid && lat < 20) begin
            busy_n += int'(o_busy);
            if (o_q_rd) begin
                if (rd_n < 4) addr[rd_n] = int'(o_q_addr);
                rd_n++;
            end
            if (lat == 6) l = lfsr_m;
            @(posedge clk);
            #1 lat++;
        end
        busy_n += int'(o_busy);
        if (!o_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({o_valid, o_busy, o_q_rd, o_q_addr, o_action, o_next_state, o_reward, o_goal} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0", {o_valid, o_busy, o_q_rd, o_q_addr, o_action, o_next_state, o_reward, o_goal});
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_greedy;
        int q[4] = '{5, 20, -3, 20};
        int lat, busy_n, rd_n, l, ea, ens, erw;
        int addr[4];
        do_step(9, q, lat, busy_n, rd_n, addr, l);
        ref_step(9, q, l, ea, ens, erw);
        n_cmp++;
        if ({o_action, o_next_state, o_reward, o_goal} !== {2'(ea), 6'(ens), 16'(erw), 1'(ens == 63)}) begin
            n_err++;
            $display("FAIL greedy_result got a=%0d ns=%0d r=%0d g=%b want a=%0d ns=%0d r=%0d", o_action, o_next_state, $signed(o_reward), o_goal, ea, ens, erw);
        end
        n_cmp++;
        if (lat != 7) begin n_err++; $display("FAIL greedy_latency got %0d want 7", lat); end
        n_cmp++;
        if (busy_n != 7) begin n_err++; $display("FAIL greedy_busy_cycles got %0d want 7", busy_n); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_action !== 2'(ea) || o_next_state !== 6'(ens)) begin
            n_err++;
            $display("FAIL greedy_hold got busy=%b valid=%b a=%0d ns=%0d want 0 0 %0d %0d", o_busy, o_valid, o_action, o_next_state, ea, ens);
        end
    endtask

    task automatic test_edges;
        int sts[4] = '{0, 55, 7, 63};
        int qs[4][4] = '{'{50, 1, 2, 3}, '{0, 9, 1, 2}, '{0, 0, 0, 9}, '{4, 1, 1, 1}};
        int lat, busy_n, rd_n, l, ea, ens, erw;
        int addr[4];
        for (int t = 0; t < 4; t++) begin
            do_step(sts[t], qs[t], lat, busy_n, rd_n, addr, l);
            ref_step(sts[t], qs[t], l, ea, ens, erw);
            n_cmp++;
            if ({o_action, o_next_state, o_reward, o_goal} !== {2'(ea), 6'(ens), 16'(erw), 1'(ens == 63)} || lat != 7) begin
                n_err++;
                $display("FAIL edge_%0d got a=%0d ns=%0d r=%0d g=%b lat=%0d want a=%0d ns=%0d r=%0d lat=7", t, o_action, o_next_state, $signed(o_reward), o_goal, lat, ea, ens, erw);
            end
        end
    endtask

    task automatic test_signed;
        int q[4] = '{-8, -2, -5, -32768};
        int lat, busy_n, rd_n, l, ea, ens, erw;
        int addr[4];
        do_step(12, q, lat, busy_n, rd_n, addr, l);
        ref_step(12, q, l, ea, ens, erw);
        n_cmp++;
        if ({o_action, o_next_state, o_reward, o_goal} !== {2'(ea), 6'(ens), 16'(erw), 1'(ens == 63)}) begin
            n_err++;
            $display("FAIL signed_result got a=%0d ns=%0d r=%0d want a=%0d ns=%0d r=%0d", o_action, o_next_state, $signed(o_reward), ea, ens, erw);
        end
        n_cmp++;
        if (rd_n != 4) begin n_err++; $display("FAIL signed_rd_cycles got %0d want 4", rd_n); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (addr[k] != 48 + k) begin n_err++; $display("FAIL signed_addr_%0d got %0d want %0d", k, addr[k], 48 + k); end
        end
    endtask

    task automatic test_random;
        int q[4];
        int st, lat, busy_n, rd_n, l, ea, ens, erw;
        int addr[4];
        for (int it = 0; it < 40; it++) begin
            st = $urandom_range(0, 63);
            for (int i = 0; i < 4; i++) q[i] = (it % 2 != 0) ? int'($urandom_range(0, 4)) - 2 : int'($signed(16'($urandom)));
            do_step(st, q, lat, busy_n, rd_n, addr, l);
            ref_step(st, q, l, ea, ens, erw);
            n_cmp++;
            if ({o_action, o_next_state, o_reward, o_goal} !== {2'(ea), 6'(ens), 16'(erw), 1'(ens == 63)} || lat != 7) begin
                n_err++;
                $display("FAIL random_%0d st=%0d got a=%0d ns=%0d r=%0d g=%b lat=%0d want a=%0d ns=%0d r=%0d lat=7", it, st, o_action, o_next_state, $signed(o_reward), o_goal, lat, ea, ens, erw);
            end
        end
    endtask

    task automatic test_back_to_back;
        int sv[30], lv[30];
        int pulses[$];
        int q[4];
        int s, ea, ens, erw;
        for (int i = 0; i < 256; i++) q_mem[i] = 16'($urandom);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            i_valid = cyc < 20;
            i_state = 6'($urandom_range(0, 63));
            sv[cyc] = int'(i_state);
            lv[cyc] = lfsr_m;
            @(posedge clk);
            #1;
            if (o_valid) begin
                pulses.push_back(cyc);
                if (cyc >= 6) begin
                    s = sv[cyc - 6];
                    for (int j = 0; j < 4; j++) q[j] = int'($signed(q_mem[4 * s + j]));
                    ref_step(s, q, lv[cyc], ea, ens, erw);
                    n_cmp++;
                    if ({o_action, o_next_state, o_reward} !== {2'(ea), 6'(ens), 16'(erw)}) begin
                        n_err++;
                        $display("FAIL b2b_result cyc=%0d got a=%0d ns=%0d r=%0d want a=%0d ns=%0d r=%0d", cyc, o_action, o_next_state, $signed(o_reward), ea, ens, erw);
                    end
                end
            end
        end
        n_cmp++;
        if (pulses.size() != 3) begin n_err++; $display("FAIL b2b_pulse_count got %0d want 3", pulses.size()); end
        for (int i = 0; i < pulses.size() && i < 3; i++) begin
            n_cmp++;
            if (pulses[i] != 6 + 7 * i) begin n_err++; $display("FAIL b2b_pulse_%0d got cycle %0d want %0d", i, pulses[i], 6 + 7 * i); end
        end
    endtask

    task automatic test_reset_mid;
        int q[4] = '{3, 1, 7, 2};
        int cnt, lat, busy_n, rd_n, l, ea, ens, erw;
        int addr[4];
        for (int i = 0; i < 4; i++) q_mem[80 + i] = 16'(q[i]);
        @(negedge clk);
        i_valid = 1;
        i_state = 6'd20;
        @(posedge clk);
        #1 i_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({o_valid, o_busy, o_q_rd, o_q_addr, o_action, o_next_state, o_reward, o_goal} !== 36'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got %h want 0", {o_valid, o_busy, o_q_rd, o_q_addr, o_action, o_next_state, o_reward, o_goal});
        end
        @(negedge clk) rst_n = 1;
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1 cnt += int'(o_valid);
        end
        n_cmp++;
        if (cnt != 0) begin n_err++; $display("FAIL midreset_no_valid got %0d pulses want 0", cnt); end
        do_step(20, q, lat, busy_n, rd_n, addr, l);
        ref_step(20, q, l, ea, ens, erw);
        n_cmp++;
        if ({o_action, o_next_state, o_reward, o_goal} !== {2'(ea), 6'(ens), 16'(erw), 1'(ens == 63)} || lat != 7) begin
            n_err++;
            $display("FAIL midreset_step got a=%0d ns=%0d r=%0d lat=%0d want a=%0d ns=%0d r=%0d lat=7", o_action, o_next_state, $signed(o_reward), lat, ea, ens, erw);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) q_mem[i] = 16'd0;
        test_reset;
        test_greedy;
        test_edges;
        test_signed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
